// File: rtl/ref_window_loader_pkg.sv
// Shared definitions for the subpixel interpolator front end and core.
// Holds the default geometry (block edge, tap count, pixel width), the
// derived window edge and flat window width, and the pixel/window types.
package subpel_pkg;

    localparam int NUM_PIXEL  = 8;
    localparam int TAPS       = 8;
    localparam int PIXEL_BITS = 8;
    localparam int DIM        = NUM_PIXEL + TAPS - 1;
    localparam int WIN_BITS   = DIM * DIM * PIXEL_BITS;

    typedef logic [PIXEL_BITS-1:0] pixel_t;
    typedef logic [WIN_BITS-1:0]   win_t;

    // Row-major flat position of pixel (row, col) inside a dim x dim window.
    function automatic int win_index(input int row, input int col, input int dim);
        return row * dim + col;
    endfunction

endpackage

// File: rtl/ref_window_loader_bank.sv
// window_bank: storage for one reference window.
// One pixel is written per enabled cycle at a flat row-major index. The
// whole window is visible as one flat vector. Asynchronous reset clears it.
module window_bank
    import subpel_pkg::*;
#(
    parameter int DIM_P = DIM,
    parameter int PIX_W = PIXEL_BITS
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                wr_en,
    input  logic [$clog2(DIM_P*DIM_P)-1:0]      wr_idx,
    input  logic [PIX_W-1:0]                    wr_pixel,
    output logic [DIM_P*DIM_P*PIX_W-1:0]        win_out
);

    localparam int FLAT_W = DIM_P * DIM_P * PIX_W;

    logic [FLAT_W-1:0] win_q;
    logic [FLAT_W-1:0] win_d;

    // Overlay the incoming pixel onto its slot; other slots keep their contents.
    always_comb begin
        win_d = win_q;
        if (wr_en) begin
            win_d[wr_idx*PIX_W +: PIX_W] = wr_pixel;
        end
    end

    // Window storage register, cleared to zero on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

    assign win_out = win_q;

endmodule

// File: rtl/ref_window_loader.sv
// ref_window_loader: assembles a row-major pixel stream into a flat
// DIM x DIM reference window for the subpixel interpolator.
// Configuration macro REF_WINDOW_PINGPONG_EN selects two ping-pong banks,
// so the next window fills while the previous one is held. Without it a
// single bank is used and input stalls while a window waits to be taken.
// A window closes on its last index or on pix_last, whichever comes first.
// It is flagged as a framing error unless both happen on the same beat.
module ref_window_loader #(
    parameter int NUM_PIXEL  = subpel_pkg::NUM_PIXEL,
    parameter int TAPS       = subpel_pkg::TAPS,
    parameter int PIXEL_BITS = subpel_pkg::PIXEL_BITS
) (
    input  logic                                                          clock,
    input  logic                                                          reset,
    input  logic                                                          pix_valid,
    output logic                                                          pix_ready,
    input  logic [PIXEL_BITS-1:0]                                         pix_data,
    input  logic                                                          pix_last,
    output logic                                                          win_valid,
    input  logic                                                          win_ready,
    output logic [(NUM_PIXEL+TAPS-1)*(NUM_PIXEL+TAPS-1)*PIXEL_BITS-1:0]  win_data,
    output logic                                                          win_error
);

    localparam int DIM   = NUM_PIXEL + TAPS - 1;
    localparam int NPIX  = DIM * DIM;
    localparam int CNT_W = $clog2(DIM);
    localparam int IDX_W = $clog2(NPIX);
    localparam int WIN_W = NPIX * PIXEL_BITS;

`ifdef REF_WINDOW_PINGPONG_EN
    localparam int NUM_BANKS = 2;
`else
    localparam int NUM_BANKS = 1;
`endif

    logic [CNT_W-1:0]     col_q, col_d;
    logic [CNT_W-1:0]     row_q, row_d;
    logic [NUM_BANKS-1:0] full_q, full_d;
    logic [NUM_BANKS-1:0] err_q, err_d;
    logic                 wb_q, wb_d;
    logic                 rb_q, rb_d;

    logic [NUM_BANKS-1:0] wr_sel;
    logic [NUM_BANKS-1:0] rd_sel;
    logic                 wr_full;
    logic                 rd_full;
    logic                 rd_err;
    logic                 beat_acc;
    logic                 win_hs;
    logic                 at_end;
    logic                 close_win;
    logic                 close_err;
    logic [IDX_W-1:0]     wr_idx;
    logic [WIN_W-1:0]     bank_data [NUM_BANKS];

    // One-hot bank selects derived from the write and read pointers.
    assign wr_sel  = NUM_BANKS'(1) << wb_q;
    assign rd_sel  = NUM_BANKS'(1) << rb_q;
    assign wr_full = |(full_q & wr_sel);
    assign rd_full = |(full_q & rd_sel);
    assign rd_err  = |(err_q & rd_sel);

    assign pix_ready = !wr_full && !reset;
    assign beat_acc  = pix_valid && pix_ready;
    assign win_hs    = rd_full && win_ready;

    assign at_end    = (row_q == CNT_W'(DIM-1)) && (col_q == CNT_W'(DIM-1));
    assign close_win = beat_acc && (at_end || pix_last);
    // A clean window has pix_last exactly on its final index.
    assign close_err = !(at_end && pix_last);
    assign wr_idx    = IDX_W'(row_q) * IDX_W'(DIM) + IDX_W'(col_q);

    // Column/row position of the next beat; restarts at 0 whenever a window closes.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (beat_acc) begin
            if (close_win) begin
                col_d = '0;
                row_d = '0;
            end else if (col_q == CNT_W'(DIM-1)) begin
                col_d = '0;
                row_d = row_q + CNT_W'(1);
            end else begin
                col_d = col_q + CNT_W'(1);
            end
        end
    end

    // Bank flags: a close marks the write bank full (with its framing status);
    // a handshake frees the read bank. Both may act on different banks at once.
    always_comb begin
        full_d = full_q;
        err_d  = err_q;
        if (close_win) begin
            full_d = full_d | wr_sel;
            err_d  = (err_q & ~wr_sel) | (close_err ? wr_sel : '0);
        end
        if (win_hs) begin
            full_d = full_d & ~rd_sel;
        end
    end

`ifdef REF_WINDOW_PINGPONG_EN
    // Ping-pong pointers: write side advances on close, read side on handshake.
    always_comb begin
        wb_d = wb_q ^ close_win;
        rb_d = rb_q ^ win_hs;
    end

    assign win_data = bank_data[rb_q];
`else
    // Single bank: both pointers stay on bank 0.
    always_comb begin
        wb_d = 1'b0;
        rb_d = 1'b0;
    end

    assign win_data = bank_data[0];
`endif

    assign win_valid = rd_full;
    assign win_error = rd_err;

    // Control state register; reset empties every bank and discards any partial window.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_q  <= '0;
            row_q  <= '0;
            full_q <= '0;
            err_q  <= '0;
            wb_q   <= 1'b0;
            rb_q   <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            full_q <= full_d;
            err_q  <= err_d;
            wb_q   <= wb_d;
            rb_q   <= rb_d;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        window_bank #(
            .DIM_P (DIM),
            .PIX_W (PIXEL_BITS)
        ) u_bank (
            .clock    (clock),
            .reset    (reset),
            .wr_en    (beat_acc && wr_sel[b]),
            .wr_idx   (wr_idx),
            .wr_pixel (pix_data),
            .win_out  (bank_data[b])
        );
    end

endmodule

// File: tb/tb_ref_window_loader.sv
// Testbench for ref_window_loader (default geometry, 15x15 window of 8-bit pixels).
// Works for both builds; REF_WINDOW_PINGPONG_EN selects dual-bank expectations.
module tb_ref_window_loader;

    localparam int DIM  = 15;
    localparam int NPIX = DIM * DIM;
    localparam int WB   = NPIX * 8;
`ifdef REF_WINDOW_PINGPONG_EN
    localparam int NB     = 2;
    localparam int EXP_BP = 225;
`else
    localparam int NB     = 1;
    localparam int EXP_BP = 0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          pix_valid;
    logic          pix_ready;
    logic [7:0]    pix_data;
    logic          pix_last;
    logic          win_valid;
    logic          win_ready;
    logic [WB-1:0] win_data;
    logic          win_error;

    ref_window_loader dut (
        .clock     (clock),
        .reset     (reset),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_last  (pix_last),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .win_error (win_error)
    );

    always #5 clock = ~clock;

    // Reference model: completed windows wait in a queue of capacity NB;
    // the window being filled is a flat buffer plus a mask of written pixels.
    typedef struct packed {
        logic [WB-1:0]   data;
        logic [NPIX-1:0] mask;
        logic            err;
    } win_rec_t;

    win_rec_t        mq[$];
    logic [WB-1:0]   f_data;
    logic [NPIX-1:0] f_mask;
    int              f_idx;
    bit              fresh;
    bit              last_acc;
    int              dut_acc_cnt;
    int              nvec;
    int              nmis;

    typedef struct {
        int beats;
        int base;
        int last;
        int err;
        int p0, p1, p2;
        int e0, e1, e2;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        f_data = '0;
        f_mask = '0;
        f_idx  = 0;
        fresh  = 1'b1;
    endtask

    task automatic check_outputs();
        int bad;
        chk("pix_ready", pix_ready, (!reset && mq.size() < NB));
        chk("win_valid", win_valid, (mq.size() > 0));
        if (reset) begin
            chk("win_error_rst", win_error, 0);
            chk("win_data_rst_zero", (win_data == '0), 1);
        end else if (mq.size() > 0) begin
            chk("win_error", win_error, mq[0].err);
            bad = -1;
            for (int p = 0; p < NPIX; p++) begin
                if (bad < 0 && mq[0].mask[p] && (win_data[p*8 +: 8] !== mq[0].data[p*8 +: 8]))
                    bad = p;
            end
            nvec++;
            if (bad >= 0) begin
                nmis++;
                $display("FAIL win_data pixel %0d: got %0h expected %0h", bad,
                         win_data[bad*8 +: 8], mq[0].data[bad*8 +: 8]);
            end
        end else if (fresh) begin
            chk("win_error_idle", win_error, 0);
        end
    endtask

    // One clock: model steps on the rising edge, outputs compared on the falling edge.
    task automatic cycle();
        bit m_ready, m_hs, acc;
        win_rec_t rec;
        m_ready  = !reset && (mq.size() < NB);
        m_hs     = !reset && (mq.size() > 0) && win_ready;
        acc      = pix_valid && m_ready;
        last_acc = acc;
        if (pix_valid && pix_ready) dut_acc_cnt++;
        @(posedge clock);
        if (!reset) begin
            if (m_hs) void'(mq.pop_front());
            if (acc) begin
                f_data[f_idx*8 +: 8] = pix_data;
                f_mask[f_idx]        = 1'b1;
                if (f_idx == NPIX-1 || pix_last) begin
                    rec.data = f_data;
                    rec.mask = f_mask;
                    rec.err  = !(f_idx == NPIX-1 && pix_last);
                    mq.push_back(rec);
                    fresh  = 1'b0;
                    f_idx  = 0;
                    f_mask = '0;
                end else begin
                    f_idx++;
                end
            end
        end
        @(negedge clock);
        check_outputs();
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l);
        int n;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = l;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 2000);
        if (!last_acc) begin
            nvec++;
            nmis++;
            $display("FAIL beat_timeout: got no acceptance expected acceptance within 2000 cycles");
        end
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        reset     = 1'b1;
        model_reset();
        #1;
        check_outputs();
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        chk("pix_ready_release", pix_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        nvec        = 0;
        nmis        = 0;
        dut_acc_cnt = 0;
        reset       = 1'b1;
        pix_valid   = 1'b0;
        pix_data    = '0;
        pix_last    = 1'b0;
        win_ready   = 1'b1;
        model_reset();

        tbl[0] = '{225, 8'h00, 225, 0,   0,  15, 224, 8'h00, 8'h0F, 8'hE0};
        tbl[1] = '{100, 8'h40, 100, 1,   0,  50,  99, 8'h40, 8'h72, 8'hA3};
        tbl[2] = '{225, 8'h11, 225, 0,   0, 100, 224, 8'h11, 8'h75, 8'hF1};
        tbl[3] = '{225, 8'h80,   0, 1,   0, 127, 224, 8'h80, 8'hFF, 8'h60};
        tbl[4] = '{  1, 8'h5A,   1, 1,   0,   0,   0, 8'h5A, 8'h5A, 8'h5A};
        tbl[5] = '{224, 8'h03, 224, 1,   0,  14, 223, 8'h03, 8'h11, 8'hE2};

        #1;
        check_outputs();
        @(negedge clock);
        do_reset();

        // Table of whole windows, consumer always ready.
        win_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < tbl[r].beats; i++)
                send_beat(8'(tbl[r].base + i), (tbl[r].last != 0) && (i == tbl[r].last - 1));
            pix_valid = 1'b0;
            pix_last  = 1'b0;
            chk("tbl_valid", win_valid, 1);
            chk("tbl_error", win_error, tbl[r].err);
            chk("tbl_probe0", win_data[tbl[r].p0*8 +: 8], tbl[r].e0);
            chk("tbl_probe1", win_data[tbl[r].p1*8 +: 8], tbl[r].e1);
            chk("tbl_probe2", win_data[tbl[r].p2*8 +: 8], tbl[r].e2);
            cycle();
            chk("tbl_one_cycle", win_valid, 0);
        end
        idle(2);

        // Backpressure: consumer stalls for 300 cycles with input held valid.
        win_ready = 1'b0;
        for (int i = 0; i < NPIX; i++) send_beat(8'(i), i == NPIX-1);
        pix_last    = 1'b0;
        dut_acc_cnt = 0;
        repeat (300) begin
            pix_valid = 1'b1;
            pix_data  = 8'($urandom);
            cycle();
        end
        chk("bp_accepts", dut_acc_cnt, EXP_BP);
        chk("bp_hold_valid", win_valid, 1);
        chk("bp_hold_probe", win_data[127:120], 8'h0F);
        chk("bp_hold_probe_last", win_data[1799:1792], 8'hE0);
        pix_valid = 1'b0;
        win_ready = 1'b1;
        idle(4);
        chk("bp_drained", win_valid, 0);

        // Reset in the middle of a fill, then a fresh clean window.
        for (int i = 0; i < 60; i++) send_beat(8'($urandom), 1'b0);
        do_reset();
        for (int i = 0; i < NPIX; i++) send_beat(8'(7*i + 3), i == NPIX-1);
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        chk("rst_win_valid", win_valid, 1);
        chk("rst_win_error", win_error, 0);
        chk("rst_first_pixel", win_data[7:0], 8'h03);
        chk("rst_second_pixel", win_data[15:8], 8'h0A);
        idle(2);

`ifdef REF_WINDOW_PINGPONG_EN
        // Close of window B lands on the same edge as the handshake of window A.
        win_ready = 1'b0;
        for (int i = 0; i < NPIX; i++) send_beat(8'(8'h20 + i), i == NPIX-1);
        for (int i = 0; i < NPIX-1; i++) send_beat(8'(8'h90 + i), 1'b0);
        win_ready = 1'b1;
        send_beat(8'h70, 1'b1);
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        chk("sim_valid", win_valid, 1);
        chk("sim_error", win_error, 0);
        chk("sim_first_pixel", win_data[7:0], 8'h90);
        chk("sim_last_pixel", win_data[1799:1792], 8'h70);
        chk("sim_pix_ready", pix_ready, 1);
        cycle();
        chk("sim_drained", win_valid, 0);
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            pix_valid = ($urandom_range(3) != 0);
            pix_data  = 8'($urandom);
            pix_last  = ($urandom_range(63) == 0);
            win_ready = ($urandom_range(2) != 0);
            cycle();
        end
        win_ready = 1'b1;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
